// File: rtl/synth_pkg.sv
// Shared types and constants for the polyphonic voice engine: wave and state
// encodings, noise LFSR constants and the output saturation helper.
package synth_pkg;

  typedef enum logic [1:0] {
    SQUARE = 2'd0,
    SAW    = 2'd1,
    TRI    = 2'd2,
    NOISE  = 2'd3
  } wave_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    MULT    = 3'd2,
    ACCUM   = 3'd3,
    PUBLISH = 3'd4
  } state_e;

  // Galois form of x^23 + x^18 + 1, shifting right.
  localparam int          LFSR_W    = 23;
  localparam logic [22:0] LFSR_POLY = 23'h420000;
  localparam logic [22:0] LFSR_SEED = 23'd1;

  function automatic int sat(input int x, input int out_w);
    int hi;
    int lo;
    hi = (1 << (out_w - 1)) - 1;
    lo = -(1 << (out_w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/synth_wave_gen.sv
// Combinational waveform generator: maps a pre-update phase, a wave select and
// the shared noise word to one signed OUT_W-bit sample.
module synth_wave_gen
  import synth_pkg::*;
#(
  parameter int ACC_W = 32,
  parameter int OUT_W = 16
) (
  input  logic [ACC_W-1:0]        phase,
  input  logic [1:0]              wave_sel,
  input  logic [OUT_W-1:0]        noise,
  output logic signed [OUT_W-1:0] wave
);

  localparam logic [OUT_W-1:0] M    = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0] M_M1 = M - 1'b1;

  logic             s;
  logic [OUT_W-1:0] u;
  logic [OUT_W-1:0] top;

  assign s   = phase[ACC_W-1];
  assign u   = phase[ACC_W-2 -: OUT_W];
  assign top = phase[ACC_W-1 -: OUT_W];

  // All arithmetic is modulo 2^OUT_W; every result fits the signed range.
  always_comb begin
    wave = '0;
    case (wave_sel)
      SQUARE:  wave = s ? (~M_M1 + 1'b1) : M_M1;
      SAW:     wave = top - M;
      TRI:     wave = s ? (M_M1 - u) : (u - M);
      NOISE:   wave = noise;
      default: wave = '0;
    endcase
  end

endmodule

// File: rtl/poly_synth_voice_engine.sv
// Time-multiplexed polyphonic oscillator and mixer: one shared datapath walks
// all voices per frame, then publishes a saturated mix. Define SYNTH_NOISE_EN to build the noise LFSR.
module poly_synth_voice_engine
  import synth_pkg::*;
#(
  parameter int N_VOICES = 8,
  parameter int ACC_W    = 32,
  parameter int VOL_W    = 16,
  parameter int OUT_W    = 16
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        sample_tick,
  input  logic [N_VOICES-1:0]         voice_enable,
  input  logic [N_VOICES*2-1:0]       waveform,
  input  logic [N_VOICES*ACC_W-1:0]   phase_inc,
  input  logic [N_VOICES*VOL_W-1:0]   volume,
  output logic [OUT_W-1:0]            out,
  output logic                        out_valid,
  output logic                        busy,
  output logic                        overrun
);

  localparam int VIDX_W = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;
  localparam int MIX_W  = OUT_W + $clog2(N_VOICES) + 1;
  localparam int PROD_W = OUT_W + VOL_W + 1;
  localparam logic [VIDX_W-1:0] LAST_V = VIDX_W'(N_VOICES - 1);

  state_e                    state_q, state_d;
  logic [VIDX_W-1:0]         v_q, v_d;
  logic [ACC_W-1:0]          phase_q [N_VOICES];
  logic [ACC_W-1:0]          phase_d [N_VOICES];
  logic signed [OUT_W-1:0]   wave_q, wave_d;
  logic [VOL_W-1:0]          vol_q, vol_d;
  logic [ACC_W-1:0]          inc_q, inc_d;
  logic [ACC_W-1:0]          p_q, p_d;
  logic                      en_q, en_d;
  logic signed [PROD_W-1:0]  prod_q, prod_d;
  logic signed [PROD_W-1:0]  contrib;
  logic signed [MIX_W-1:0]   mix_q, mix_d;
  logic [OUT_W-1:0]          out_q, out_d;
  logic                      out_valid_q, out_valid_d;
  logic                      overrun_q, overrun_d;
  logic                      do_load, do_mult, do_accum, do_publish;
  logic [OUT_W-1:0]          noise_word;
  logic signed [OUT_W-1:0]   wave_w;

`ifdef SYNTH_NOISE_EN
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (do_publish) lfsr_d = {1'b0, lfsr_q[LFSR_W-1:1]} ^ (lfsr_q[0] ? LFSR_POLY : '0);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) lfsr_q <= LFSR_SEED;
    else          lfsr_q <= lfsr_d;
  end

  assign noise_word = lfsr_q[OUT_W-1:0];
`else
  assign noise_word = '0;
`endif

  synth_wave_gen #(.ACC_W(ACC_W), .OUT_W(OUT_W)) u_wave_gen (
    .phase    (phase_q[v_q]),
    .wave_sel (waveform[2*v_q +: 2]),
    .noise    (noise_word),
    .wave     (wave_w)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sample_tick) state_d = LOAD;
      LOAD:    state_d = MULT;
      MULT:    state_d = ACCUM;
      ACCUM:   state_d = (v_q == LAST_V) ? PUBLISH : LOAD;
      PUBLISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q != IDLE);
    do_load    = (state_q == LOAD);
    do_mult    = (state_q == MULT);
    do_accum   = (state_q == ACCUM);
    do_publish = (state_q == PUBLISH);
  end

  always_comb begin
    v_d         = v_q;
    phase_d     = phase_q;
    wave_d      = wave_q;
    vol_d       = vol_q;
    inc_d       = inc_q;
    p_d         = p_q;
    en_d        = en_q;
    prod_d      = prod_q;
    mix_d       = mix_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    contrib     = prod_q >>> VOL_W;
    // Any tick outside IDLE (PUBLISH included) is dropped and remembered.
    overrun_d   = overrun_q | (sample_tick & busy);
    if (state_q == IDLE) v_d = '0;
    if (do_load) begin
      en_d   = voice_enable[v_q];
      wave_d = voice_enable[v_q] ? wave_w : '0;
      vol_d  = volume[v_q*VOL_W +: VOL_W];
      inc_d  = phase_inc[v_q*ACC_W +: ACC_W];
      p_d    = phase_q[v_q];
      if (v_q == '0) mix_d = '0;
    end
    if (do_mult) begin
      prod_d = $signed({{(VOL_W+1){wave_q[OUT_W-1]}}, wave_q}) *
               $signed({{(OUT_W+1){1'b0}}, vol_q});
    end
    if (do_accum) begin
      mix_d          = mix_q + MIX_W'(contrib);
      phase_d[v_q]   = en_q ? (p_q + inc_q) : '0;
      v_d            = v_q + VIDX_W'(1);
    end
    if (do_publish) begin
      out_d       = OUT_W'(sat(int'(mix_q), OUT_W));
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      v_q         <= '0;
      for (int i = 0; i < N_VOICES; i++) phase_q[i] <= '0;
      wave_q      <= '0;
      vol_q       <= '0;
      inc_q       <= '0;
      p_q         <= '0;
      en_q        <= 1'b0;
      prod_q      <= '0;
      mix_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      v_q         <= v_d;
      phase_q     <= phase_d;
      wave_q      <= wave_d;
      vol_q       <= vol_d;
      inc_q       <= inc_d;
      p_q         <= p_d;
      en_q        <= en_d;
      prod_q      <= prod_d;
      mix_q       <= mix_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;

endmodule
